// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // Instruction fields held while a memory op is in flight.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        rd_w_en;
    logic        is_store;
    logic [2:0]  funct3;
    logic [63:0] exu_result;
    logic [63:0] rs2;
  } lsu_req_t;

  // Byte strobes for an access of 2**sz bytes at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // Natural alignment check; byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-bus interface between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store shift/strobes, load extract/extend,
// misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic        misaligned
);

  logic [63:0] shifted;

  assign wmask      = size_mask(funct3[1:0]) << off;
  assign wdata      = store_data << {off, 3'b000};
  assign shifted    = rdata >> {off, 3'b000};
  assign misaligned = is_misaligned(funct3[1:0], off);

  // Truncate the lane-0 value to the access size, then sign/zero extend.
  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: passes non-memory ops straight through, runs loads/stores
// over a req/gnt/rvalid bus with an optional WAIT timeout.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_w_en,
  input  logic        in_mem_r_en,
  input  logic        in_mem_w_en,
  input  logic [2:0]  in_funct3,
  input  logic [XLEN-1:0] in_exu_result,
  input  logic [XLEN-1:0] in_x_rs2,
  mem_stage_lsu_if.master bus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [4:0]  out_rd,
  output logic        out_rd_w_en,
  output logic [XLEN-1:0] out_exu_result,
  output logic [XLEN-1:0] out_lsu_r_data,
  output logic        out_lsu_fault
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_e     state, state_nxt;
  lsu_req_t       lat, in_req;
  logic [63:0]    r_data;
  logic           fault;
  logic [CW-1:0]  cnt;

  logic           is_mem;
  logic           timeout_hit;
  logic [2:0]     al_funct3;
  logic [63:0]    al_addr;
  logic [7:0]     al_wmask;
  logic [63:0]    al_wdata;
  logic [63:0]    al_load;
  logic           al_misaligned;

  assign is_mem = in_mem_r_en | in_mem_w_en;

  assign in_req = '{
    pc:         in_pc,
    inst:       in_inst,
    rd:         in_rd,
    rd_w_en:    in_rd_w_en,
    is_store:   in_mem_w_en,
    funct3:     in_funct3,
    exu_result: in_exu_result,
    rs2:        in_x_rs2
  };

  // Counter holds the number of WAIT cycles already spent; the current one
  // is the last allowed when cnt+1 reaches TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt) + 1) == TIMEOUT);

  // Alignment checks look at the incoming op in IDLE, at the latched op otherwise.
  assign al_funct3 = (state == S_IDLE) ? in_funct3     : lat.funct3;
  assign al_addr   = (state == S_IDLE) ? in_exu_result : lat.exu_result;

  lsu_align u_align (
    .funct3     (al_funct3),
    .off        (al_addr[2:0]),
    .store_data (lat.rs2),
    .rdata      (bus.mem_rdata),
    .wmask      (al_wmask),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid && is_mem) state_nxt = al_misaligned ? S_DONE : S_REQ;
      S_REQ:  if (bus.mem_gnt)        state_nxt = bus.mem_rvalid ? S_DONE : S_WAIT;
      S_WAIT: if (bus.mem_rvalid || timeout_hit) state_nxt = S_DONE;
      S_DONE: if (out_ready)          state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Field latch, load-data capture, fault flag and WAIT counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat    <= '0;
      r_data <= '0;
      fault  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid && is_mem) begin
          lat    <= in_req;
          r_data <= '0;
          fault  <= al_misaligned;
          cnt    <= '0;
        end
        S_REQ: if (bus.mem_gnt) begin
          cnt <= '0;
          if (bus.mem_rvalid && !lat.is_store) r_data <= al_load;
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (bus.mem_rvalid) begin
            if (!lat.is_store) r_data <= al_load;
          end else if (timeout_hit) begin
            fault  <= 1'b1;
            r_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus drive: only REQ presents a request, everything else idles at zero.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    if (state == S_REQ) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = lat.is_store;
      bus.mem_addr  = {lat.exu_result[63:3], 3'b000};
      bus.mem_wdata = lat.is_store ? al_wdata : '0;
      bus.mem_wmask = lat.is_store ? al_wmask : '0;
    end
  end

  // Downstream outputs: pass-through in IDLE, latched copy otherwise.
  always_comb begin
    in_ready       = (state == S_IDLE);
    out_valid      = 1'b0;
    out_pc         = lat.pc;
    out_inst       = lat.inst;
    out_rd         = lat.rd;
    out_rd_w_en    = lat.rd_w_en & ~fault;
    out_exu_result = lat.exu_result;
    out_lsu_r_data = r_data;
    out_lsu_fault  = fault;
    case (state)
      S_IDLE: begin
        out_valid      = in_valid & ~is_mem;
        out_pc         = in_pc;
        out_inst       = in_inst;
        out_rd         = in_rd;
        out_rd_w_en    = in_rd_w_en;
        out_exu_result = in_exu_result;
        out_lsu_r_data = '0;
        out_lsu_fault  = 1'b0;
      end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: pass-through, loads, stores,
// misalignment, bus stalls, timeout and reset mid-transaction.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [4:0]  in_rd;
  logic        in_rd_w_en, in_mem_r_en, in_mem_w_en;
  logic [2:0]  in_funct3;
  logic [63:0] in_exu_result, in_x_rs2;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic [4:0]  out_rd;
  logic        out_rd_w_en;
  logic [63:0] out_exu_result, out_lsu_r_data;
  logic        out_lsu_fault;

  int ntests = 0;
  int nfail  = 0;

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.XLEN(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_rd_w_en(in_rd_w_en),
    .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en), .in_funct3(in_funct3),
    .in_exu_result(in_exu_result), .in_x_rs2(in_x_rs2),
    .bus(bus.master),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_rd(out_rd), .out_rd_w_en(out_rd_w_en),
    .out_exu_result(out_exu_result), .out_lsu_r_data(out_lsu_r_data),
    .out_lsu_fault(out_lsu_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction at a negedge; it is accepted at the next posedge.
  task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] rs2, input logic rdwe);
    in_valid      = 1'b1;
    in_mem_r_en   = r;
    in_mem_w_en   = w;
    in_funct3     = f3;
    in_exu_result = addr;
    in_x_rs2      = rs2;
    in_rd_w_en    = rdwe;
    in_rd         = 5'd7;
    in_pc         = 32'h100;
    in_inst       = 32'h13;
  endtask

  task automatic next;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; in_pc = 0; in_inst = 0; in_rd = 0; in_rd_w_en = 0;
    in_mem_r_en = 0; in_mem_w_en = 0; in_funct3 = 0; in_exu_result = 0; in_x_rs2 = 0;
    out_ready = 1'b1;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_wmask", bus.mem_wmask, 0);
    check("rst_fault", out_lsu_fault, 0);
    check("rst_in_ready", in_ready, 1);
    next(); next();
    rst = 1'b1;

    // ADD pass-through, zero latency
    next();
    issue(0, 0, 3'b000, 64'h1234, 0, 1);
    #1;
    check("add_out_valid", out_valid, 1);
    check("add_exu", out_exu_result, 64'h1234);
    check("add_in_ready", in_ready, 1);
    check("add_rdata", out_lsu_r_data, 0);
    check("add_rd_w_en", out_rd_w_en, 1);
    next(); in_valid = 0; #1;
    check("add_drop", out_valid, 0);

    // LW 0x8000_0004 with single-cycle gnt+rvalid
    next();
    issue(1, 0, 3'b010, 64'h8000_0004, 0, 1);
    #1;
    check("lw_accept_valid", out_valid, 0);
    next(); in_valid = 0;
    check("lw_req", bus.mem_req, 1);
    check("lw_addr", bus.mem_addr, 64'h8000_0000);
    check("lw_we", bus.mem_we, 0);
    check("lw_in_ready", in_ready, 0);
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h8765_4321_0000_0000;
    next(); bus.mem_gnt = 0; bus.mem_rvalid = 0;
    check("lw_valid", out_valid, 1);
    check("lw_rdata", out_lsu_r_data, 64'hFFFF_FFFF_8765_4321);
    check("lw_fault", out_lsu_fault, 0);
    check("lw_req_done", bus.mem_req, 0);
    next();
    check("lw_idle", out_valid, 0);
    check("lw_idle_ready", in_ready, 1);

    // SB 0x1003, rs2 0xAB
    issue(0, 1, 3'b000, 64'h1003, 64'hAB, 0);
    next(); in_valid = 0;
    check("sb_req", bus.mem_req, 1);
    check("sb_we", bus.mem_we, 1);
    check("sb_wmask", bus.mem_wmask, 8'h08);
    check("sb_wdata", bus.mem_wdata, 64'h0000_0000_AB00_0000);
    check("sb_addr", bus.mem_addr, 64'h1000);
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    next(); bus.mem_gnt = 0; bus.mem_rvalid = 0;
    check("sb_valid", out_valid, 1);
    check("sb_rdata", out_lsu_r_data, 0);
    next();
    check("sb_one_cycle", out_valid, 0);

    // LH 0x2001 misaligned: no bus request, fault, rd_w_en cleared
    issue(1, 0, 3'b001, 64'h2001, 0, 1);
    next(); in_valid = 0;
    check("lh_no_req", bus.mem_req, 0);
    check("lh_valid", out_valid, 1);
    check("lh_fault", out_lsu_fault, 1);
    check("lh_rd_w_en", out_rd_w_en, 0);
    next();
    check("lh_idle", out_valid, 0);

    // LD 0x3008: gnt after 3 REQ cycles, rvalid on 4th WAIT cycle, out_ready low 2 cycles
    issue(1, 0, 3'b011, 64'h3008, 0, 1);
    next(); in_valid = 0;
    check("ld_req1", bus.mem_req, 1);
    next();
    check("ld_req2", bus.mem_req, 1);
    check("ld_ready2", in_ready, 0);
    next();
    check("ld_req3", bus.mem_req, 1);
    check("ld_addr3", bus.mem_addr, 64'h3008);
    bus.mem_gnt = 1;
    next(); bus.mem_gnt = 0;
    check("ld_wait_noreq", bus.mem_req, 0);
    check("ld_wait_ready", in_ready, 0);
    next(); next(); next();
    check("ld_wait4_valid", out_valid, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 64'h0123_4567_89AB_CDEF; out_ready = 0;
    next(); bus.mem_rvalid = 0; bus.mem_rdata = 0;
    check("ld_done_valid1", out_valid, 1);
    check("ld_done_data1", out_lsu_r_data, 64'h0123_4567_89AB_CDEF);
    next();
    check("ld_done_valid2", out_valid, 1);
    check("ld_done_data2", out_lsu_r_data, 64'h0123_4567_89AB_CDEF);
    check("ld_done_exu2", out_exu_result, 64'h3008);
    check("ld_done_ready2", in_ready, 0);
    out_ready = 1;
    next();
    check("ld_idle", out_valid, 0);

    // LW 0x4000 timeout: gnt, then no rvalid for 4 WAIT cycles
    issue(1, 0, 3'b010, 64'h4000, 0, 1);
    next(); in_valid = 0;
    bus.mem_gnt = 1;
    next(); bus.mem_gnt = 0;
    next(); next(); next();
    check("to_wait4", out_valid, 0);
    next();
    check("to_valid", out_valid, 1);
    check("to_fault", out_lsu_fault, 1);
    check("to_rdata", out_lsu_r_data, 0);
    check("to_rd_w_en", out_rd_w_en, 0);
    next();
    check("to_idle", out_valid, 0);

    // Reset in WAIT, late rvalid ignored
    issue(1, 0, 3'b011, 64'h5000, 0, 1);
    next(); in_valid = 0;
    bus.mem_gnt = 1;
    next(); bus.mem_gnt = 0;
    rst = 1'b0; #1;
    check("rw_valid", out_valid, 0);
    check("rw_req", bus.mem_req, 0);
    check("rw_ready", in_ready, 1);
    next(); rst = 1'b1;
    next();
    bus.mem_rvalid = 1; bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check("rw_late_valid", out_valid, 0);
    next(); bus.mem_rvalid = 0;
    check("rw_late_valid2", out_valid, 0);
    check("rw_late_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
